mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the multicycle RISC-V core's single unified instruction/data memory. It shares the memory between port 0 (processor datapath/controller fetch and load/store) and port 1 (program loader / DMA). It serialises their accesses with round-robin fairness and a fixed-latency request/ready handshake. The block sits between the core's memory address/write path and the synchronous memory array.

---
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter and sequencer for the core's
// single unified instruction/data memory.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   m0_req/we/addr/wdata   port 0 (datapath) request, held until ready
//   m0_ready, m0_rdata     port 0 one-cycle completion pulse, read data
//   m1_*                   same as port 0, for the loader/DMA port
//   mem_en, mem_we         memory access strobe and write enable
//   mem_addr, mem_wdata    memory address and write data
//   mem_rdata              memory read data, valid LAT cycles after mem_en
//   busy                   high whenever a transaction is in progress
//   grant                  one-hot owner of the current transaction
//
// Every output is a register or a decode of registered state, so no
// combinational path exists from any input to any output.
module mem_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ready,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ready,
    output logic [DW-1:0] m1_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy,
    output logic [1:0]    grant
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] LAT_C = 4'(LAT);

    state_t        state;
    state_t        state_nx;

    // last: index of the most recently granted port (1 = port 1).
    logic          last;
    logic          last_nx;
    logic [1:0]    grant_q;
    logic [1:0]    grant_nx;
    logic          we_q;
    logic          we_nx;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_nx;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] wdata_nx;
    logic [3:0]    cnt;
    logic [3:0]    cnt_nx;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_nx;

    // Port 1 wins when it is the only requester, or on a tie when
    // port 0 was the last one served.
    logic          pick1;
    logic          any_req;

    assign any_req = m0_req | m1_req;
    assign pick1   = m1_req & (~m0_req | ~last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 1'b1;
            grant_q <= 2'b00;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= 4'd0;
            rdata_q <= '0;
        end else begin
            state   <= state_nx;
            last    <= last_nx;
            grant_q <= grant_nx;
            we_q    <= we_nx;
            addr_q  <= addr_nx;
            wdata_q <= wdata_nx;
            cnt     <= cnt_nx;
            rdata_q <= rdata_nx;
        end
    end

    always_comb begin
        state_nx = state;
        last_nx  = last;
        grant_nx = grant_q;
        we_nx    = we_q;
        addr_nx  = addr_q;
        wdata_nx = wdata_q;
        cnt_nx   = cnt;
        rdata_nx = rdata_q;

        unique case (state)
            IDLE: begin
                if (any_req) begin
                    last_nx  = pick1;
                    grant_nx = pick1 ? 2'b10 : 2'b01;
                    we_nx    = pick1 ? m1_we    : m0_we;
                    addr_nx  = pick1 ? m1_addr  : m0_addr;
                    wdata_nx = pick1 ? m1_wdata : m0_wdata;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                cnt_nx   = 4'd1;
                state_nx = WAIT;
            end
            WAIT: begin
                cnt_nx = cnt + 4'd1;
                // cnt counts cycles since the strobe; the memory word is
                // on mem_rdata exactly when it reaches LAT.
                if (cnt == LAT_C) begin
                    rdata_nx = mem_rdata;
                    state_nx = RESP;
                end
            end
            RESP: begin
                grant_nx = 2'b00;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign mem_en    = (state == ISSUE);
    assign mem_we    = (state == ISSUE) & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign busy  = (state != IDLE);
    assign grant = grant_q;

    assign m0_ready = (state == RESP) & grant_q[0];
    assign m1_ready = (state == RESP) & grant_q[1];

    // One shared capture register feeds both ports; data is only
    // meaningful alongside the owner's ready pulse.
    assign m0_rdata = rdata_q;
    assign m1_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a LAT=1 instance
// (single read) and a LAT=3 instance (write/read, ties, drop, reset).
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- instance A, LAT=1, port 0 only ----------------
    logic        a_req;
    logic        a_we;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_ready;
    logic [31:0] a_rdata;
    logic        a_m1_ready;
    logic [31:0] a_m1_rdata;
    logic        a_en;
    logic        a_mwe;
    logic [31:0] a_maddr;
    logic [31:0] a_mwdata;
    logic [31:0] a_mrdata;
    logic        a_busy;
    logic [1:0]  a_grant;

    mem_arbiter #(.AW(32), .DW(32), .LAT(1)) u_a (
        .clk(clk), .rst(rst),
        .m0_req(a_req), .m0_we(a_we), .m0_addr(a_addr),
        .m0_wdata(a_wdata), .m0_ready(a_ready), .m0_rdata(a_rdata),
        .m1_req(1'b0), .m1_we(1'b0), .m1_addr(32'h0),
        .m1_wdata(32'h0), .m1_ready(a_m1_ready), .m1_rdata(a_m1_rdata),
        .mem_en(a_en), .mem_we(a_mwe), .mem_addr(a_maddr),
        .mem_wdata(a_mwdata), .mem_rdata(a_mrdata),
        .busy(a_busy), .grant(a_grant)
    );

    // ---------------- instance B, LAT=3, both ports ----------------
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_ready;
    logic [31:0] m0_rdata;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_ready;
    logic [31:0] m1_rdata;
    logic        b_en;
    logic        b_we;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic [31:0] b_rdata;
    logic        b_busy;
    logic [1:0]  b_grant;

    mem_arbiter #(.AW(32), .DW(32), .LAT(3)) u_b (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .mem_en(b_en), .mem_we(b_we), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .mem_rdata(b_rdata),
        .busy(b_busy), .grant(b_grant)
    );

    // ---------------- memory models ----------------
    function automatic logic [31:0] pat(input logic [31:0] ad);
        if (ad == 32'h40) return 32'hDEADBEEF;
        return {ad[15:0], ~ad[15:0]};
    endfunction

    logic [31:0] pipe_a;
    always @(posedge clk) pipe_a <= pat(a_maddr);
    assign a_mrdata = pipe_a;

    logic [31:0] memw_b [0:255];
    logic [255:0] wv_b = '0;
    logic [31:0] pipe_b [0:2];

    always @(posedge clk) begin
        if (b_en && b_we) begin
            memw_b[b_addr[9:2]] <= b_wdata;
            wv_b[b_addr[9:2]]   <= 1'b1;
        end
        pipe_b[0] <= wv_b[b_addr[9:2]] ? memw_b[b_addr[9:2]] : pat(b_addr);
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign b_rdata = pipe_b[2];

    // ---------------- checks ----------------
    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Strobe rule: mem_we only with mem_en, one mem_en per completed
    // transaction (aborted ones are discarded on reset).
    int en_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            en_cnt = 0;
        end else begin
            if (b_we && !b_en) chk("b_we_without_en", 32'(b_we), 32'd0);
            if (a_mwe && !a_en) chk("a_we_without_en", 32'(a_mwe), 32'd0);
            if (b_en) en_cnt++;
            if (m0_ready || m1_ready) begin
                chk("en_per_txn", 32'(en_cnt), 32'd1);
                en_cnt = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    int t_prev;
    int exp_p;

    initial begin
        rst = 1'b1;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        t_prev = 0;
        tick(2);

        chk("rst_b_busy", 32'(b_busy), 0);
        chk("rst_b_grant", 32'(b_grant), 0);
        chk("rst_b_en", 32'(b_en), 0);
        chk("rst_b_addr", b_addr, 0);
        chk("rst_b_rdy", 32'({m0_ready, m1_ready}), 0);
        chk("rst_a_busy", 32'(a_busy), 0);
        chk("rst_a_wdata", a_mwdata, 0);

        // single read, LAT=1
        rst = 1'b0;
        a_req = 1; a_we = 0; a_addr = 32'h40;
        tick();
        chk("s1_en", 32'(a_en), 1);
        chk("s1_we", 32'(a_mwe), 0);
        chk("s1_addr", a_maddr, 32'h40);
        chk("s1_grant", 32'(a_grant), 32'b01);
        chk("s1_busy", 32'(a_busy), 1);
        tick();
        chk("s1_en_wait", 32'(a_en), 0);
        chk("s1_rdy_early", 32'(a_ready), 0);
        tick();
        chk("s1_rdy", 32'(a_ready), 1);
        chk("s1_rdata", a_rdata, 32'hDEADBEEF);
        chk("s1_m1_rdata", a_m1_rdata, 32'hDEADBEEF);
        chk("s1_m1_rdy", 32'(a_m1_ready), 0);
        a_req = 0;
        tick();
        chk("s1_rdy_off", 32'(a_ready), 0);
        chk("s1_idle_grant", 32'(a_grant), 0);
        chk("s1_idle_busy", 32'(a_busy), 0);

        // port 1 write then read, LAT=3
        m1_req = 1; m1_we = 1; m1_addr = 32'h80; m1_wdata = 32'h12345678;
        tick();
        chk("s2_en", 32'(b_en), 1);
        chk("s2_we", 32'(b_we), 1);
        chk("s2_addr", b_addr, 32'h80);
        chk("s2_wdata", b_wdata, 32'h12345678);
        chk("s2_grant", 32'(b_grant), 32'b10);
        tick(3);
        chk("s2_rdy_early", 32'(m1_ready), 0);
        tick();
        chk("s2_wr_rdy", 32'(m1_ready), 1);
        chk("s2_wr_m0rdy", 32'(m0_ready), 0);
        m1_we = 0;
        tick();
        chk("s2_idle_busy", 32'(b_busy), 0);
        chk("s2_idle_rdy", 32'(m1_ready), 0);
        tick();
        chk("s2_rd_en", 32'(b_en), 1);
        chk("s2_rd_we", 32'(b_we), 0);
        tick(4);
        chk("s2_rd_rdy", 32'(m1_ready), 1);
        chk("s2_rd_data", m1_rdata, 32'h12345678);
        m1_req = 0;
        tick();

        // ties held from reset: 0,1,0,1
        rst = 1'b1;
        m0_req = 1; m0_addr = 32'h100;
        m1_req = 1; m1_addr = 32'h104;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_p = i % 2;
            tick();
            chk("s3_grant", 32'(b_grant), exp_p ? 32'b10 : 32'b01);
            tick(4);
            chk("s3_rdy0", 32'(m0_ready), exp_p ? 0 : 1);
            chk("s3_rdy1", 32'(m1_ready), exp_p ? 1 : 0);
            chk("s3_rdata", exp_p ? m1_rdata : m0_rdata,
                exp_p ? 32'h0104FEFB : 32'h0100FEFF);
            if (i > 0) chk("s3_spacing", 32'(cyc - t_prev), 32'd6);
            t_prev = cyc;
            if (i == 3) begin
                m0_req = 0;
                m1_req = 0;
            end
            tick();
            chk("s3_idle_grant", 32'(b_grant), 0);
        end

        // port 0 drops req during WAIT
        m0_req = 1;
        tick();
        chk("s4_grant", 32'(b_grant), 32'b01);
        tick();
        m0_req = 0;
        tick(3);
        chk("s4_rdy", 32'(m0_ready), 1);
        chk("s4_rdata", m0_rdata, 32'h0100FEFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s4_no_en", 32'(b_en), 0);
            chk("s4_no_busy", 32'(b_busy), 0);
        end

        // tie after port 0 served -> port 1; reset it mid-WAIT
        m0_req = 1;
        m1_req = 1;
        tick();
        chk("s5_grant_rr", 32'(b_grant), 32'b10);
        tick(2);
        #2 rst = 1'b1;
        #1;
        chk("s5_rst_busy", 32'(b_busy), 0);
        chk("s5_rst_grant", 32'(b_grant), 0);
        chk("s5_rst_en", 32'(b_en), 0);
        chk("s5_rst_rdy", 32'({m0_ready, m1_ready}), 0);
        #2 rst = 1'b0;
        tick();
        chk("s5_grant_after", 32'(b_grant), 32'b01);
        chk("s5_en_after", 32'(b_en), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s5_no_m1_rdy", 32'(m1_ready), 0);
        end
        tick();
        chk("s5_m0_rdy", 32'(m0_ready), 1);
        chk("s5_m1_rdy", 32'(m1_ready), 0);
        m0_req = 0;
        m1_req = 0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
